nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
Sequencer that adds two WIDTH-bit operands one nibble per cycle, using the team's existing 4-bit ripple carry adder as its datapath.
- Downstream side: drives the adder's in_a/in_b/cin through add_a/add_b/add_cin.
- Upstream side: consumes the adder's sum/cout through add_sum/add_cout.
- Operands and result move over valid/ready handshakes.
- Lets wide additions reuse one small adder at the cost of latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
NIBBLES, WIDTH/4, derived local value; number of adder passes per operation.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair offered
in_ready  output  1  block can accept operands
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
cin  input  1  initial carry-in
add_a  output  4  nibble of A to adder in_a
add_b  output  4  nibble of B to adder in_b
add_cin  output  1  carry to adder cin
add_sum  input  4  adder sum (combinational return)
add_cout  input  1  adder carry-out (combinational return)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  final carry-out
busy  output  1  high in RUN or DONE

Behaviour:
- Single clock domain. Reset is asynchronous, active-high (rst); all registers clear immediately on assertion.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, busy=0, add_a=0, add_b=0, add_cin=0, nibble counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_a, in_b into shift registers; carry register <= cin; counter <= 0; go to RUN.
- RUN:
  - add_a = A_reg[3:0], add_b = B_reg[3:0], add_cin = carry register.
  - Each cycle: A_reg/B_reg shift right 4; sum register shifts right 4 with add_sum inserted at [WIDTH-1:WIDTH-4]; carry register <= add_cout; counter++.
  - After NIBBLES RUN cycles (counter == NIBBLES-1 at the edge), go to DONE.
- DONE:
  - out_valid=1; sum = sum register; cout = carry register.
  - Outputs are held stable while out_ready=0.
  - On out_ready, go to IDLE at the next edge. No same-cycle re-accept.
- add_a/add_b/add_cin are 0 in IDLE and DONE. They are registered-derived, with no combinational path from in_* ports.
- in_ready=0 in RUN and DONE. in_valid is ignored there, and in_a/in_b/cin may change freely.
- Latency: accept edge + NIBBLES RUN cycles. out_valid rises NIBBLES cycles after the accept edge (4 for WIDTH=16). Throughput is one operation per NIBBLES+2 cycles minimum.
- Arithmetic: {cout,sum} = in_a + in_b + cin, modulo 2^(WIDTH+1). Wrap-around of sum is expected behaviour, not an error.
- Boundary cases:
  - WIDTH=4: a single RUN cycle.
  - Reset mid-RUN or in DONE: partial result discarded, return to IDLE, out_valid=0.
  - in_valid and rst together: reset wins.

Optional Feature:
OVERFLOW_FLAG_EN
- Defined:
  - Adds output port ovf (1 bit), reset 0, valid with out_valid.
  - ovf = signed two's-complement overflow = (A[WIDTH-1]==B[WIDTH-1]) && (sum[WIDTH-1]!=A[WIDTH-1]).
  - The operand MSBs are captured at accept time.
- Undefined: no ovf port and no associated registers; all other behaviour unchanged.

Test Plan:
1. WIDTH=16: in_a=0x1234, in_b=0x4321, cin=0 accepted at cycle 0 -> out_valid at cycle 4; sum=0x5555, cout=0; add_cin=0 every RUN cycle.
2. in_a=0xFFFF, in_b=0x0001, cin=0 -> sum=0x0000, cout=1; add_cin=1 on RUN cycles 2-4 (carry ripples through nibbles).
3. in_a=0xFFFF, in_b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1. Hold out_ready=0 for 5 cycles -> sum/cout/out_valid stable, in_ready=0 and new in_valid ignored. Then out_ready=1 -> IDLE next cycle, in_ready=1.
4. Assert rst for 1 cycle during RUN cycle 2 of 0x00FF+0x0F0F -> out_valid never rises, all outputs return to reset values at once. A following 0x0001+0x0002 returns 0x0003, cout=0.
5. Back-to-back: out_ready held 1 with in_valid held 1 -> operations accepted every NIBBLES+2 = 6 cycles, results in order.
6. OVERFLOW_FLAG_EN defined: 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1. 0x8000+0xFFFF -> sum=0x7FFF, cout=1, ovf=1. 0x1000+0x2000 -> ovf=0.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per cycle through an external 4-bit adder.
// Define OVERFLOW_FLAG_EN to add the signed-overflow output ovf.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef OVERFLOW_FLAG_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

`ifdef OVERFLOW_FLAG_EN
  logic msb_a_q, msb_a_d;
  logic msb_b_q, msb_b_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef OVERFLOW_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msb_a_q <= 1'b0;
      msb_b_q <= 1'b0;
    end else begin
      msb_a_q <= msb_a_d;
      msb_b_q <= msb_b_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef OVERFLOW_FLAG_EN
    msb_a_d = msb_a_q;
    msb_b_d = msb_b_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
`ifdef OVERFLOW_FLAG_EN
          msb_a_d = in_a[WIDTH-1];
          msb_b_d = in_b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        // Result builds from the top; after NIBBLES shifts nibble 0 sits at [3:0].
        a_d              = a_q >> 4;
        b_d              = b_q >> 4;
        s_d              = s_q >> 4;
        s_d[WIDTH-1 -: 4] = add_sum;
        carry_d          = add_cout;
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic run;
  assign run = (state_q == RUN);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = run || out_valid;
  assign add_a     = run ? a_q[3:0] : 4'h0;
  assign add_b     = run ? b_q[3:0] : 4'h0;
  assign add_cin   = run ? carry_q : 1'b0;
  assign sum       = s_q;
  assign cout      = carry_q;

`ifdef OVERFLOW_FLAG_EN
  assign ovf = out_valid && (msb_a_q == msb_b_q) &&
               (s_q[WIDTH-1] != msb_a_q);
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder with a behavioural 4-bit adder.
// Build with OVERFLOW_FLAG_EN defined to exercise the ovf output too.
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         cin;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .cin      (cin),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
`ifdef OVERFLOW_FLAG_EN
    .ovf      (ovf),
`endif
    .busy     (busy)
  );

  // Stand-in for the shared 4-bit ripple adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic c);
    exp_t   e;
    longint ua, ub, t, sa, sbv, sr, lim;
    ua  = longint'(a);
    ub  = longint'(b);
    t   = ua + ub + longint'(c);
    e.s = W'(t % (64'sd1 <<< W));
    e.c = (t >= (64'sd1 <<< W));
    lim = 64'sd1 <<< (W - 1);
    sa  = (ua >= lim) ? ua - 2 * lim : ua;
    sbv = (ub >= lim) ? ub - 2 * lim : ub;
    sr  = sa + sbv + longint'(c);
    e.o = (sr >= lim) || (sr < -lim);
    return e;
  endfunction

  function automatic logic carry_into(input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      input logic c, input int k);
    longint m;
    m = 64'sd1 <<< (4 * k);
    return ((longint'(a) % m + longint'(b) % m + longint'(c)) / m) != 0;
  endfunction

  // Monitor: pops one expectation per completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("in_ready_low_in_done", in_ready, 0);
      chk("busy_in_done", busy, 1);
      if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_result: got sum %0h with empty queue",
                   sum);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sum", sum, e.s);
          chk("cout", cout, e.c);
`ifdef OVERFLOW_FLAG_EN
          chk("ovf", ovf, e.o);
`endif
        end
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, output int acc_cyc);
    int   n;
    logic acc;
    n = 0;
    in_a = a;
    in_b = b;
    cin = c;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready && !rst;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    acc_cyc = cyc;
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    cin = 1'($urandom);
    if (!acc) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end else begin
      sb.push_back(model(a, b, c));
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c);
    int acc;
    issue(a, b, c, acc);
    for (int k = 0; k < NIB; k++) begin
      @(negedge clk);
      chk("add_a", add_a, (a >> (4 * k)) & 4'hF);
      chk("add_b", add_b, (b >> (4 * k)) & 4'hF);
      chk("add_cin", add_cin, carry_into(a, b, c, k));
      chk("out_valid_low_in_run", out_valid, 0);
    end
    @(negedge clk);
    chk("latency_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, prev, n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    cin = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add", {add_a, add_b, add_cin}, 0);
`ifdef OVERFLOW_FLAG_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0);

    // Stall the consumer and check outputs hold.
    out_ready = 1'b0;
    issue(16'hFFFF, 16'hFFFF, 1'b1, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    chk("stall_reached_done", out_valid, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_a = W'($urandom);
      in_b = W'($urandom);
      @(negedge clk);
      chk("stall_sum", sum, 16'hFFFF);
      chk("stall_cout", cout, 1);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Reset in the middle of RUN, with in_valid asserted alongside.
    issue(16'h00FF, 16'h0F0F, 1'b0, acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_add", {add_a, add_b, add_cin}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    void'(sb.pop_back());
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_idle", {out_valid, busy}, 0);
    end
    @(posedge clk);
    #1;
    run_op(16'h0001, 16'h0002, 1'b0);

`ifdef OVERFLOW_FLAG_EN
    run_op(16'h7FFF, 16'h0001, 1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b0);
    run_op(16'h1000, 16'h2000, 1'b0);
`endif

    // Back-to-back throughput.
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), acc);
      if (i > 0) chk("b2b_spacing", acc - prev, NIB + 2);
      prev = acc;
    end

    // Random operands, gaps and consumer stalls.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      issue(W'($urandom), W'($urandom), 1'($urandom), acc);
      n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
        n++;
      end
      out_ready = 1'b1;
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
